// File: rtl/sha256_selftest_pkg.sv
// rtl/sha256_selftest_pkg.sv - shared types and known-answer vectors for the SHA-256 self-test
// Holds the sequencer state enum, width defaults and the four single-block padded messages with their digests.
package sha256_selftest_pkg;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, DONE} state_t;

  localparam int WORD_W_DEF   = 32;
  localparam int DIGEST_W_DEF = 256;
  localparam int ROM_VECS     = 4;

  // Blocks are stored word 0 first in the MSBs; bit length sits in the last 64 bits.
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_A     = {32'h61800000, 448'h0, 32'h00000008};
  localparam logic [511:0] BLK_FOX   = {32'h54686520, 32'h71756963, 32'h6b206272, 32'h6f776e20,
                                        32'h666f7820, 32'h6a756d70, 32'h73206f76, 32'h65722074,
                                        32'h6865206c, 32'h617a7920, 32'h646f6780, 128'h0,
                                        32'h00000158};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_A     = 256'hca978112ca1bbdcacac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] DIG_FOX   = 256'hd7a8fbb307d7809469ca9abcb0082e4f8d5651e46d3cdb762d02d0bf37c9e592;

  function automatic logic [511:0] vec_block(input logic [1:0] idx);
    case (idx)
      2'd0:    return BLK_ABC;
      2'd1:    return BLK_EMPTY;
      2'd2:    return BLK_A;
      default: return BLK_FOX;
    endcase
  endfunction

  function automatic logic [255:0] vec_digest(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIG_ABC;
      2'd1:    return DIG_EMPTY;
      2'd2:    return DIG_A;
      default: return DIG_FOX;
    endcase
  endfunction

endpackage

// File: rtl/sha256_selftest_if.sv
// rtl/sha256_selftest_if.sv - message stream and digest return between self-test and hash core
interface sha256_selftest_if
  import sha256_selftest_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int DIGEST_W = DIGEST_W_DEF
);
  logic [WORD_W-1:0]   msg_word;
  logic                msg_valid;
  logic                msg_last;
  logic                msg_ready;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;

  modport master (
    output msg_word, msg_valid, msg_last,
    input  msg_ready, digest, digest_valid
  );

  modport slave (
    input  msg_word, msg_valid, msg_last,
    output msg_ready, digest, digest_valid
  );
endinterface

// File: rtl/sha256_selftest_seq_rom.sv
// rtl/sha256_selftest_seq_rom.sv - sha256_vector_rom: combinational message word and expected digest lookup
module sha256_vector_rom
  import sha256_selftest_pkg::*;
#(
  parameter int WORD_W        = WORD_W_DEF,
  parameter int WORDS_PER_VEC = 16,
  parameter int DIGEST_W      = DIGEST_W_DEF,
  localparam int WIDX_W       = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1
) (
  input  logic [1:0]          i_vec_idx,
  input  logic [WIDX_W-1:0]   i_word_idx,
  output logic [WORD_W-1:0]   o_msg_word,
  output logic [DIGEST_W-1:0] o_exp_digest
);
  logic [511:0] w_blk;

  assign w_blk        = vec_block(i_vec_idx);
  assign o_exp_digest = vec_digest(i_vec_idx);

  always_comb begin
    o_msg_word = '0;
    for (int w = 0; w < WORDS_PER_VEC; w++) begin
      if (i_word_idx == WIDX_W'(w)) o_msg_word = w_blk[511-WORD_W*w -: WORD_W];
    end
  end
endmodule

// File: rtl/sha256_selftest_seq.sv
// rtl/sha256_selftest_seq.sv - sequential SHA-256 built-in self-test: stream vectors, compare digests, tally
// Optional SHA256_SELFTEST_ERRINJ_EN adds err_inj, which corrupts vector 0's expected digest for one run.
module sha256_selftest_seq
  import sha256_selftest_pkg::*;
#(
  parameter int NUM_VECTORS   = 4,
  parameter int WORDS_PER_VEC = 16,
  parameter int WORD_W        = WORD_W_DEF,
  parameter int DIGEST_W      = DIGEST_W_DEF,
  parameter int TIMEOUT_CYC   = 1024,
  localparam int CW           = $clog2(NUM_VECTORS + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
`ifdef SHA256_SELFTEST_ERRINJ_EN
  input  logic             err_inj,
`endif
  sha256_selftest_if.master hash,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    pass_cnt,
  output logic [CW-1:0]    fail_cnt,
  output logic [7:0]       first_fail,
  output logic             LED_GOOD,
  output logic             LED_BAD
);
  localparam int WIDX_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_vec_idx;
  logic [WIDX_W-1:0]     r_word_idx;
  logic [TW-1:0]         r_tmo_cnt;
  logic [DIGEST_W-1:0]   r_digest;
  logic                  r_dig_ok;
  logic [CW-1:0]         r_pass_cnt, r_fail_cnt;
  logic [7:0]            r_first_fail;
  logic                  r_done, r_led_good, r_led_bad;

  logic [WORD_W-1:0]     w_rom_word;
  logic [DIGEST_W-1:0]   w_exp_digest, w_exp_eff;
  logic                  w_start_ok, w_hs, w_word_last, w_vec_last, w_tmo, w_match;

  sha256_vector_rom #(
    .WORD_W        (WORD_W),
    .WORDS_PER_VEC (WORDS_PER_VEC),
    .DIGEST_W      (DIGEST_W)
  ) u_rom (
    .i_vec_idx    (r_vec_idx[1:0]),
    .i_word_idx   (r_word_idx),
    .o_msg_word   (w_rom_word),
    .o_exp_digest (w_exp_digest)
  );

`ifdef SHA256_SELFTEST_ERRINJ_EN
  logic r_err_inj;

  always_ff @(posedge C) begin
    if (R)               r_err_inj <= 1'b0;
    else if (w_start_ok) r_err_inj <= err_inj;
  end

  assign w_exp_eff = w_exp_digest ^ {{(DIGEST_W-1){1'b0}}, r_err_inj && (r_vec_idx == 8'd0)};
`else
  assign w_exp_eff = w_exp_digest;
`endif

  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_hs        = hash.msg_valid && hash.msg_ready;
  assign w_word_last = (r_word_idx == WIDX_W'(WORDS_PER_VEC - 1));
  assign w_vec_last  = (r_vec_idx == 8'(NUM_VECTORS - 1));
  assign w_tmo       = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
  // A timed-out vector never captured a digest, so it cannot match.
  assign w_match     = r_dig_ok && (r_digest == w_exp_eff);

  assign hash.msg_valid = (r_state == SEND);
  assign hash.msg_last  = (r_state == SEND) && w_word_last;
  assign hash.msg_word  = w_rom_word;

  assign busy       = (r_state == SEND) || (r_state == WAIT) || (r_state == CHECK);
  assign done       = r_done;
  assign pass_cnt   = r_pass_cnt;
  assign fail_cnt   = r_fail_cnt;
  assign first_fail = r_first_fail;
  assign LED_GOOD   = r_led_good;
  assign LED_BAD    = r_led_bad;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (start)                            w_state_nxt = SEND;
      SEND:       if (w_hs && w_word_last)              w_state_nxt = WAIT;
      WAIT:       if (hash.digest_valid || w_tmo)       w_state_nxt = CHECK;
      CHECK:      w_state_nxt = w_vec_last ? DONE : SEND;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state      <= IDLE;
      r_vec_idx    <= '0;
      r_word_idx   <= '0;
      r_tmo_cnt    <= '0;
      r_digest     <= '0;
      r_dig_ok     <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_first_fail <= 8'hFF;
      r_done       <= 1'b0;
      r_led_good   <= 1'b0;
      r_led_bad    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_ok) begin
        r_vec_idx    <= '0;
        r_word_idx   <= '0;
        r_pass_cnt   <= '0;
        r_fail_cnt   <= '0;
        r_first_fail <= 8'hFF;
        r_done       <= 1'b0;
        r_led_good   <= 1'b0;
        r_led_bad    <= 1'b0;
      end

      if ((r_state == SEND) && w_hs) begin
        r_word_idx <= w_word_last ? '0 : r_word_idx + 1'b1;
        if (w_word_last) begin
          r_tmo_cnt <= '0;
          r_dig_ok  <= 1'b0;
        end
      end

      if (r_state == WAIT) begin
        if (hash.digest_valid) begin
          r_digest <= hash.digest;
          r_dig_ok <= 1'b1;
        end else if (!w_tmo) begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end

      if (r_state == CHECK) begin
        if (w_match) begin
          r_pass_cnt <= r_pass_cnt + 1'b1;
        end else begin
          r_fail_cnt <= r_fail_cnt + 1'b1;
          if (r_fail_cnt == '0) r_first_fail <= r_vec_idx;
        end
        if (w_vec_last) begin
          r_done     <= 1'b1;
          r_led_good <= (r_fail_cnt == '0) && w_match;
          r_led_bad  <= !((r_fail_cnt == '0) && w_match);
        end else begin
          r_vec_idx <= r_vec_idx + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sha256_selftest_seq.sv
// tb/tb_sha256_selftest_seq.sv - directed bench for sha256_selftest_seq with a known-answer hash core model
module tb_sha256_selftest_seq;
  localparam int CORE_LAT = 3;

  logic C = 1'b0;
  logic R = 1'b1;
  logic start = 1'b0;
  logic busy, done, LED_GOOD, LED_BAD;
  logic [2:0] pass_cnt, fail_cnt;
  logic [7:0] first_fail;
`ifdef SHA256_SELFTEST_ERRINJ_EN
  logic err_inj = 1'b0;
`endif

  always #5 C = ~C;

  sha256_selftest_if #(.WORD_W(32), .DIGEST_W(256)) bus ();

  sha256_selftest_seq #(.NUM_VECTORS(4), .TIMEOUT_CYC(64)) dut (
    .C          (C),
    .R          (R),
    .start      (start),
`ifdef SHA256_SELFTEST_ERRINJ_EN
    .err_inj    (err_inj),
`endif
    .hash       (bus.master),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail),
    .LED_GOOD   (LED_GOOD),
    .LED_BAD    (LED_BAD)
  );

  string        msgs [4] = '{"abc", "", "a", "The quick brown fox jumps over the lazy dog"};
  logic [255:0] digs [4] = '{
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855,
    256'hca978112ca1bbdcacac231b39a23dc4da786eff8147c4e72b9807785afee48bb,
    256'hd7a8fbb307d7809469ca9abcb0082e4f8d5651e46d3cdb762d02d0bf37c9e592};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  // Bench-to-model requests (bench writes *_req, model writes *_ack)
  int clr_req = 0, clr_ack = 0, inj_req = 0, inj_ack = 0;
  int corrupt_vec = -1, drop_vec = -1;
  bit bp_en = 1'b0;

  // Model-owned observations
  int hs_total = 0, stall_errs = 0, proto_errs = 0, stall_cyc = 0;
  int m_wcnt = 0, m_blk = 0, m_pend = -1;
  int last_edge [8];
  logic [511:0] m_blk_data;
  logic [255:0] m_dig;

  function automatic logic [511:0] pad_msg(input string s);
    logic [511:0] b;
    int n;
    b = '0;
    n = s.len();
    for (int i = 0; i < n; i++) b[511-8*i -: 8] = s[i];
    b[511-8*n -: 8] = 8'h80;
    b[63:0] = 64'(n * 8);
    return b;
  endfunction

  function automatic logic [255:0] lookup(input logic [511:0] blk);
    for (int i = 0; i < 4; i++) if (blk == pad_msg(msgs[i])) return digs[i];
    return '0;
  endfunction

  // Hash core model: acts on the falling edge, so everything it drives is stable at the next rising edge.
  initial begin
    logic       prev_stall, prev_last;
    logic [31:0] prev_word;
    logic [255:0] d;
    prev_stall = 1'b0; prev_last = 1'b0; prev_word = '0;
    bus.msg_ready = 1'b0; bus.digest_valid = 1'b0; bus.digest = '0;
    forever begin
      @(negedge C);
      bus.digest_valid = 1'b0;
      if (R || clr_req != clr_ack) begin
        m_wcnt = 0; m_blk = 0; m_pend = -1; prev_stall = 1'b0; clr_ack = clr_req;
      end
      bus.msg_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!bus.msg_valid || bus.msg_word !== prev_word || bus.msg_last !== prev_last))
        stall_errs++;
      if (!R && bus.msg_valid && bus.msg_ready) begin
        hs_total++;
        if (m_wcnt < 16) m_blk_data[511-32*m_wcnt -: 32] = bus.msg_word;
        if (bus.msg_last !== (m_wcnt == 15)) proto_errs++;
        m_wcnt++;
        if (bus.msg_last) begin
          d = lookup(m_blk_data);
          if (m_blk == corrupt_vec) d[255] = ~d[255];
          if (m_blk != drop_vec) begin m_pend = CORE_LAT; m_dig = d; end
          if (m_blk < 8) last_edge[m_blk] = cyc + 1;
          m_blk++;
          m_wcnt = 0;
        end
      end
      prev_stall = bus.msg_valid && !bus.msg_ready;
      prev_word  = bus.msg_word;
      prev_last  = bus.msg_last;
      if (prev_stall) stall_cyc++;
      if (m_pend == 0) begin
        bus.digest_valid = 1'b1; bus.digest = m_dig; m_pend = -1;
      end else if (m_pend > 0) begin
        m_pend--;
      end
      if (inj_req != inj_ack) begin
        bus.digest_valid = 1'b1; bus.digest = digs[0]; inj_ack = inj_req;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic run_start();
    start = 1'b1;
    clr_req++;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (done) break;
      tick();
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_result(input string tag, input int p, input int f, input int ff);
    chk({tag, "_pass"}, 64'(pass_cnt), 64'(p));
    chk({tag, "_fail"}, 64'(fail_cnt), 64'(f));
    chk({tag, "_first"}, 64'(first_fail), 64'(ff));
    chk({tag, "_good"}, 64'(LED_GOOD), 64'(f == 0));
    chk({tag, "_bad"}, 64'(LED_BAD), 64'(f != 0));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_valid"}, 64'(bus.msg_valid), 64'd0);
    chk({tag, "_last"}, 64'(bus.msg_last), 64'd0);
    chk({tag, "_pass"}, 64'(pass_cnt), 64'd0);
    chk({tag, "_fail"}, 64'(fail_cnt), 64'd0);
    chk({tag, "_first"}, 64'(first_fail), 64'hFF);
    chk({tag, "_leds"}, 64'({LED_GOOD, LED_BAD}), 64'd0);
  endtask

  initial begin
    int hs0, st0, sc0, k;
    R = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    R = 1'b0;
    tick();

    // 1: clean run with the reference model
    run_start();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_valid", 64'(bus.msg_valid), 64'd1);
    chk("t1_word0", 64'(bus.msg_word), 64'h61626380);
    wait_done("t1_done");
    chk_result("t1", 4, 0, 8'hFF);
    chk("t1_proto", 64'(proto_errs), 64'd0);

    // digest_valid while DONE must be ignored
    inj_req++;
    repeat (4) tick();
    chk("ign_done", 64'(done), 64'd1);
    chk("ign_pass", 64'(pass_cnt), 64'd4);

    // 2: model corrupts bit 255 of vector 2
    corrupt_vec = 2;
    run_start();
    wait_done("t2_done");
    chk_result("t2", 3, 1, 2);
    corrupt_vec = -1;

    // 3: random backpressure, plus a start pulse mid-run that must be ignored
    bp_en = 1'b1;
    hs0 = hs_total; st0 = stall_errs; sc0 = stall_cyc;
    run_start();
    repeat (30) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t3_done");
    chk_result("t3", 4, 0, 8'hFF);
    chk("t3_hs", 64'(hs_total - hs0), 64'd64);
    chk("t3_stable", 64'(stall_errs - st0), 64'd0);
    chk("t3_stalled", 64'((stall_cyc - sc0) > 0), 64'd1);
    chk("t3_proto", 64'(proto_errs), 64'd0);
    bp_en = 1'b0;

    // 4: vector 1 digest never returned -> timeout
    drop_vec = 1;
    run_start();
    for (k = 0; k < 500; k++) begin
      if (fail_cnt != 0) break;
      tick();
    end
    chk("t4_tmo_seen", 64'(fail_cnt), 64'd1);
    chk("t4_tmo_delay", 64'(cyc - last_edge[1]), 64'd65);
    wait_done("t4_done");
    chk_result("t4", 3, 1, 1);
    drop_vec = -1;

    // 5: reset during SEND of vector 2, then a fresh run
    run_start();
    for (k = 0; k < 500; k++) begin
      if (m_blk == 2 && m_wcnt >= 4) break;
      tick();
    end
    chk("t5_midsend", 64'({bus.msg_valid, pass_cnt}), 64'({1'b1, 3'd2}));
    R = 1'b1;
    tick();
    chk_reset("t5_rst");
    R = 1'b0;
    run_start();
    wait_done("t5_done");
    chk_result("t5", 4, 0, 8'hFF);

`ifdef SHA256_SELFTEST_ERRINJ_EN
    // 6: injected expected-digest error on vector 0, then a clean rerun
    err_inj = 1'b1;
    run_start();
    err_inj = 1'b0;
    wait_done("t6_done");
    chk_result("t6", 3, 1, 0);
    run_start();
    wait_done("t6b_done");
    chk_result("t6b", 4, 0, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
